mult_share_arbiter: RTL and testbench

Round-robin controller that shares one `MultiplierUnit` instance between `NREQ` requesters. It accepts one operation at a time over per-requester valid/ready handshakes, sequences the multiplier's `valid` pulse and `res_ready` completion, then returns the product to the winning requester. It sits between client datapaths (e.g. the divider/ALU front ends) and the single multiplier.

---
 rtl/mult_arb_pkg.sv | 21 ++
 rtl/mult_share_arbiter_rr_picker.sv | 35 +++
 rtl/mult_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// The optional WAIT watchdog is enabled by defining MULT_ARB_TIMEOUT_EN.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int unsigned PARALLELISM_DEFAULT = 32;
  localparam int unsigned NREQ_DEFAULT        = 2;
  localparam int unsigned TIMEOUT_DEFAULT     = 255;

  // Counter width able to hold the value TIMEOUT itself.
  function automatic int unsigned wdog_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant,
// returned both one-hot and as an index.
module rr_picker #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   index,
  output logic            any
);

  int unsigned base;
  int unsigned idx;
  logic        found;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = |valid;
    found  = 1'b0;
    base   = 32'(last);
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (!found && valid[IW'(idx)]) begin
        found              = 1'b1;
        onehot[IW'(idx)]   = 1'b1;
        index              = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier between NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT-state watchdog that reports resp_err.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned parallelism = PARALLELISM_DEFAULT,
  parameter int unsigned NREQ        = NREQ_DEFAULT,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0]             req_usigned,
  input  logic [NREQ*parallelism-1:0] req_multiplicand,
  input  logic [NREQ*parallelism-1:0] req_multiplier,
  output logic [NREQ-1:0]             resp_valid,
  input  logic [NREQ-1:0]             resp_ready,
  output logic [2*parallelism-1:0]    resp_product,
  output logic                        resp_err,
  output logic                        mul_valid,
  output logic                        mul_usigned,
  output logic [parallelism-1:0]      mul_multiplicand,
  output logic [parallelism-1:0]      mul_multiplier,
  input  logic [2*parallelism-1:0]    mul_product,
  input  logic                        mul_res_ready
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t             state;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          grant;
  logic                   res_q;
  logic                   rise;
  logic [NREQ-1:0]        pick_onehot;
  logic [IW-1:0]          pick_index;
  logic                   pick_any;
  logic [parallelism-1:0] sel_a;
  logic [parallelism-1:0] sel_b;
  logic                   sel_u;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned WDW = wdog_width(TIMEOUT);
  logic [WDW-1:0] wdog;
`else
  assign resp_err = 1'b0;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .valid  (req_valid),
    .last   (last_grant),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  // Completion is the rising edge only, so a level left high by a previous op is ignored.
  assign rise      = mul_res_ready & ~res_q;
  assign req_ready = (state == IDLE) ? pick_onehot : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_u = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_onehot[k]) begin
        sel_a = req_multiplicand[k*parallelism +: parallelism];
        sel_b = req_multiplier[k*parallelism +: parallelism];
        sel_u = req_usigned[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      last_grant       <= IW'(NREQ - 1);
      grant            <= '0;
      res_q            <= 1'b0;
      resp_valid       <= '0;
      resp_product     <= '0;
      mul_valid        <= 1'b0;
      mul_usigned      <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      resp_err         <= 1'b0;
      wdog             <= '0;
`endif
    end else begin
      res_q     <= mul_res_ready;
      mul_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant            <= pick_index;
            last_grant       <= pick_index;
            mul_usigned      <= sel_u;
            mul_multiplicand <= sel_a;
            mul_multiplier   <= sel_b;
            mul_valid        <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
          wdog  <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (rise) begin
            resp_product <= mul_product;
            resp_valid   <= NREQ'(1) << grant;
`ifdef MULT_ARB_TIMEOUT_EN
            resp_err     <= 1'b0;
`endif
            state        <= RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (wdog == WDW'(TIMEOUT - 1)) begin
            resp_product <= '0;
            resp_valid   <= NREQ'(1) << grant;
            resp_err     <= 1'b1;
            state        <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        RESP: begin
          if (|(resp_valid & resp_ready)) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter with a behavioural multiplier and a
// transaction-level scoreboard; also covers the MULT_ARB_TIMEOUT_EN build.
module tb_mult_share_arbiter;

  localparam int unsigned P = 32;
  localparam int unsigned N = 2;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     req_usigned = '0;
  logic [N*P-1:0]   req_multiplicand = '0;
  logic [N*P-1:0]   req_multiplier = '0;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready = '0;
  logic [2*P-1:0]   resp_product;
  logic             resp_err;
  logic             mul_valid;
  logic             mul_usigned;
  logic [P-1:0]     mul_multiplicand;
  logic [P-1:0]     mul_multiplier;
  logic [2*P-1:0]   mul_product = '0;
  logic             mul_res_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .parallelism (P),
    .NREQ        (N),
    .TIMEOUT     (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_usigned      (req_usigned),
    .req_multiplicand (req_multiplicand),
    .req_multiplier   (req_multiplier),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_product     (resp_product),
    .resp_err         (resp_err),
    .mul_valid        (mul_valid),
    .mul_usigned      (mul_usigned),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_res_ready    (mul_res_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic u, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (u) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Behavioural multiplier: 33-cycle latency, res_ready rises on done, drops on next valid.
  int         m_cnt = 0;
  logic       stall = 1'b0;
  logic       kick  = 1'b0;
  logic [31:0] ma, mb;
  logic       mu;

  always @(posedge clk) begin
    if (rst) begin
      mul_res_ready <= 1'b0;
      m_cnt         <= 0;
      mul_product   <= '0;
    end else if (mul_valid) begin
      mul_res_ready <= 1'b0;
      m_cnt         <= 33;
      ma            <= mul_multiplicand;
      mb            <= mul_multiplier;
      mu            <= mul_usigned;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !stall) begin
        mul_res_ready <= 1'b1;
        mul_product   <= ref_mul(mu, ma, mb);
      end
    end else if (kick) begin
      mul_res_ready <= 1'b1;
    end
  end

  // Scoreboard: one outstanding op, round robin from last grant, response after completion.
  logic        chk_en = 1'b1;
  logic        busy = 1'b0, resp_on = 1'b0, issue_now = 1'b0, prev_rr = 1'b0, acc;
  int unsigned mlast = N - 1, mgrant = 0, w;
  logic [31:0] ea, eb;
  logic        eu;
  logic [63:0] eprod;
  logic [N-1:0] exp_rr, exp_rv;
  int unsigned grants[$];

  function automatic int unsigned rr_win(input logic [N-1:0] v, input int unsigned last);
    for (int unsigned k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return N;
  endfunction

  always @(negedge clk) begin
    if (rst || !chk_en) begin
      busy = 1'b0; resp_on = 1'b0; issue_now = 1'b0; prev_rr = 1'b0; mlast = N - 1;
    end else begin
      w      = rr_win(req_valid, mlast);
      acc    = !busy && (w < N);
      exp_rr = '0;
      if (acc) exp_rr[w] = 1'b1;
      exp_rv = '0;
      if (resp_on) exp_rv[mgrant] = 1'b1;
      check_eq("req_ready", 64'(req_ready), 64'(exp_rr));
      check_eq("mul_valid", 64'(mul_valid), 64'(issue_now));
      check_eq("resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (issue_now) begin
        check_eq("mul_multiplicand", 64'(mul_multiplicand), 64'(ea));
        check_eq("mul_multiplier", 64'(mul_multiplier), 64'(eb));
        check_eq("mul_usigned", 64'(mul_usigned), 64'(eu));
      end
      if (resp_on) begin
        check_eq("resp_product", resp_product, eprod);
        check_eq("resp_err", 64'(resp_err), 64'(0));
      end
      if (resp_on && resp_ready[mgrant]) begin
        busy = 1'b0; resp_on = 1'b0;
      end else if (busy && !issue_now && !resp_on && mul_res_ready && !prev_rr) begin
        resp_on = 1'b1;
      end
      prev_rr   = mul_res_ready;
      issue_now = acc;
      if (acc) begin
        busy   = 1'b1;
        mgrant = w;
        mlast  = w;
        eu     = req_usigned[w];
        ea     = req_multiplicand[w*P +: P];
        eb     = req_multiplier[w*P +: P];
        eprod  = ref_mul(eu, ea, eb);
        grants.push_back(w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = '1;
    repeat (60) tick();
    resp_ready = '0;
  endtask

  task automatic wait_resp(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid == '0 && n < limit);
    if (resp_valid == '0) check_eq("resp_wait_expired", 64'(n), 64'(0));
  endtask

  task automatic wait_mul(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mul_valid && n < limit);
    if (!mul_valid) check_eq("mul_valid_wait_expired", 64'(n), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check_eq({tag, "_mul_valid"}, 64'(mul_valid), 64'(0));
    check_eq({tag, "_mul_a"}, 64'(mul_multiplicand), 64'(0));
    check_eq({tag, "_mul_b"}, 64'(mul_multiplier), 64'(0));
    check_eq({tag, "_mul_u"}, 64'(mul_usigned), 64'(0));
    check_eq({tag, "_resp_product"}, resp_product, 64'(0));
    check_eq({tag, "_resp_err"}, 64'(resp_err), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=expired exp=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] held;
    int n;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Directed: requester 0 signed, then requester 1 unsigned with the same operands.
    tick();
    req_valid = 2'b01; req_usigned = 2'b00;
    req_multiplicand = {32'h0, 32'h0000_0016};
    req_multiplier   = {32'h0, 32'hFFFF_FFEB};
    tick(); req_valid = '0;
    wait_resp(200);
    check_eq("signed_resp_valid", 64'(resp_valid), 64'(2'b01));
    check_eq("signed_product", resp_product, 64'hFFFF_FFFF_FFFF_FE32);
    check_eq("signed_err", 64'(resp_err), 64'(0));
    tick(); resp_ready = 2'b01;
    tick(); resp_ready = '0;

    tick();
    req_valid = 2'b10; req_usigned = 2'b10;
    req_multiplicand = {32'h0000_0016, 32'h0};
    req_multiplier   = {32'hFFFF_FFEB, 32'h0};
    tick(); req_valid = '0;
    wait_resp(200);
    check_eq("unsigned_resp_valid", 64'(resp_valid), 64'(2'b10));
    check_eq("unsigned_product", resp_product, 64'h0000_0015_FFFF_FE32);
    tick(); resp_ready = 2'b10;
    tick(); resp_ready = '0;

    // Both requesting continuously from reset: grants alternate starting at 0.
    do_reset();
    grants.delete();
    req_multiplicand = {$urandom, $urandom};
    req_multiplier   = {$urandom, $urandom};
    req_usigned = 2'b01;
    req_valid = 2'b11; resp_ready = 2'b11;
    n = 0;
    while (grants.size() < 4 && n < 400) begin
      tick();
      n++;
    end
    req_valid = '0;
    check_eq("rr_grant_count", 64'(grants.size() >= 4), 64'(1));
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check_eq($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 2));
    drain();

    // Response backpressure: result and handshakes frozen while resp_ready stays low.
    tick(); req_valid = 2'b01;
    tick(); req_valid = '0;
    wait_resp(200);
    held = resp_product;
    tick(); req_valid = 2'b11;
    repeat (10) begin
      @(negedge clk);
      check_eq("hold_resp_valid", 64'(resp_valid), 64'(2'b01));
      check_eq("hold_product", resp_product, held);
      check_eq("hold_req_ready", 64'(req_ready), 64'(0));
      check_eq("hold_mul_valid", 64'(mul_valid), 64'(0));
    end
    tick(); req_valid = '0; resp_ready = 2'b11;
    tick(); resp_ready = '0;

    // Reset while waiting for the multiplier; a late completion must be ignored.
    drain();
    tick(); req_valid = 2'b01;
    tick(); req_valid = '0;
    wait_mul(20);
    repeat (5) tick();
    rst = 1'b1;
    tick(); rst = 1'b0; kick = 1'b1;
    tick(); kick = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_reset_outputs("midreset");
    end

    // Randomized traffic with boundary operands.
    repeat (3000) begin
      tick();
      req_valid   = N'($urandom);
      req_usigned = N'($urandom);
      req_multiplicand = {pick_op(), pick_op()};
      req_multiplier   = {pick_op(), pick_op()};
      for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(3) != 0);
    end
    drain();

    // Multiplier never completes.
    tick(); chk_en = 1'b0; stall = 1'b1;
    tick(); req_valid = 2'b01;
    tick(); req_valid = '0;
    wait_mul(20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid == '0 && n < 1000);
`ifdef MULT_ARB_TIMEOUT_EN
    check_eq("timeout_latency", 64'(n), 64'(TO + 1));
    check_eq("timeout_resp_valid", 64'(resp_valid), 64'(2'b01));
    check_eq("timeout_err", 64'(resp_err), 64'(1));
    check_eq("timeout_product", resp_product, 64'(0));
`else
    check_eq("nowd_resp_valid", 64'(resp_valid), 64'(0));
    check_eq("nowd_req_ready", 64'(req_ready), 64'(0));
    check_eq("nowd_err", 64'(resp_err), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
